wishbone_top: RTL and testbench

- Self-contained Wishbone B4 subsystem: one master front-end FSM plus two identical slave memories on a shared internal bus.
- The external (bench/CPU-side) request port selects a slave with a one-hot 2-bit strobe.
- The block performs single or incrementing-burst (CTI-driven) reads and writes, and reports handshake results.
- It exposes every internal bus signal on debug ports for bring-up.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_slave_mem.sv | 43 ++++
 rtl/wishbone_top.sv | 160 ++++++++++++++++
 tb/tb_wishbone_top.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone subsystem: master FSM states and cycle-type codes.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } wb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_slave_mem.sv
// Word-addressed memory slave with byte-select writes and a registered ack.
// Read data is combinational and zero outside an access or for unselected bytes.
module wb_slave_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ack <= cyc && stb;
      if (cyc && stb && we) begin
        for (int b = 0; b < SEL_WIDTH; b++)
          if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int b = 0; b < SEL_WIDTH; b++)
      if (cyc && stb && sel[b]) rdata[8*b +: 8] = mem[addr][8*b +: 8];
  end

endmodule

// File: rtl/wishbone_top.sv
// Wishbone master front-end FSM driving two memory slaves on a shared bus,
// with CTI-driven burst addressing and full debug visibility of the internal bus.
module wishbone_top
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [DATA_WIDTH-1:0] data_o,
  input  logic                  we_o,
  input  logic [1:0]            stb_o,
  input  logic                  cyc_o,
  input  logic [SEL_WIDTH-1:0]  sel_o,
  input  logic [2:0]            cti_input,
  input  logic                  tag_add,
  output logic                  ack_i,
  output logic                  err_i,
  output logic [DATA_WIDTH-1:0] data_i,
  output logic [1:0]            state_out,
  output logic [ADDR_WIDTH-1:0] dbg_w_addr,
  output logic [DATA_WIDTH-1:0] dbg_w_data_m2s,
  output logic [DATA_WIDTH-1:0] dbg_w_data_s2m,
  output logic [ADDR_WIDTH-1:0] counter,
  output logic                  dbg_w_we,
  output logic                  dbg_tag_add,
  output logic                  dbg_w_cyc,
  output logic                  dbg_w_ack,
  output logic                  dbg_w_err,
  output logic [SEL_WIDTH-1:0]  dbg_w_sel,
  output logic [1:0]            dbg_w_stb,
  output logic [2:0]            dbg_cti
);

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  wb_state_e             state;
  logic                  we_p0, tag_p0;
  logic [SEL_WIDTH-1:0]  sel_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [2:0]            cti_p0;
  logic [1:0]            stb_p0;
  logic [ADDR_WIDTH-1:0] ea_p0;

  logic                  req_ok, bus_cyc;
  logic [1:0]            bus_stb, s_ack;
  logic [DATA_WIDTH-1:0] s_rdata0, s_rdata1, rd_mux;
  logic [ADDR_WIDTH-1:0] ea_next;

  // Illegal requests (both slaves or no bytes) never reach a slave.
  assign req_ok  = (stb_p0 != 2'b11) && (sel_p0 != '0);
  assign bus_cyc = (state == REQ) && cyc_o;
  assign bus_stb = (bus_cyc && req_ok) ? stb_p0 : 2'b00;
  assign rd_mux  = s_rdata0 | s_rdata1;
  assign ea_next = (tag_add || cti_input != CTI_INCR) ? addr_o : addr_o + counter;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      counter <= '0;
      ack_i   <= 1'b0;
      err_i   <= 1'b0;
      data_i  <= '0;
      we_p0   <= 1'b0;
      tag_p0  <= 1'b0;
      sel_p0  <= '0;
      data_p0 <= '0;
      cti_p0  <= '0;
      stb_p0  <= '0;
      ea_p0   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cyc_o && stb_o != 2'b00) begin
            we_p0   <= we_o;
            tag_p0  <= tag_add;
            sel_p0  <= sel_o;
            data_p0 <= data_o;
            cti_p0  <= cti_input;
            stb_p0  <= stb_o;
            ea_p0   <= ea_next;
            state   <= REQ;
          end else if (!cyc_o && cti_input == CTI_EOB) begin
            counter <= '0;
          end
        end
        REQ: begin
          if (!cyc_o) begin
            state <= IDLE;
          end else if (!req_ok) begin
            state <= ERR;
            err_i <= 1'b1;
          end else begin
            state <= ACK;
            ack_i <= 1'b1;
            if (!we_p0) data_i <= rd_mux;
            case (cti_p0)
              CTI_INCR:               if (!tag_p0) counter <= counter + ONE;
              CTI_EOB:                counter <= '0;
              CTI_CLASSIC, CTI_CONST: ;
              default:                ;
            endcase
          end
        end
        ACK, ERR: begin
          // Wait for the requester to drop its strobe so a held request is not repeated.
          if (stb_o == 2'b00) begin
            state <= IDLE;
            ack_i <= 1'b0;
            err_i <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  wb_slave_mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_slave0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cyc   (bus_cyc),
    .stb   (bus_stb[0]),
    .we    (we_p0),
    .sel   (sel_p0),
    .addr  (ea_p0),
    .wdata (data_p0),
    .rdata (s_rdata0),
    .ack   (s_ack[0])
  );

  wb_slave_mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_slave1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .cyc   (bus_cyc),
    .stb   (bus_stb[1]),
    .we    (we_p0),
    .sel   (sel_p0),
    .addr  (ea_p0),
    .wdata (data_p0),
    .rdata (s_rdata1),
    .ack   (s_ack[1])
  );

  assign state_out      = state;
  assign dbg_w_addr     = ea_p0;
  assign dbg_w_data_m2s = data_p0;
  assign dbg_w_data_s2m = rd_mux;
  assign dbg_w_we       = we_p0;
  assign dbg_tag_add    = tag_p0;
  assign dbg_w_cyc      = bus_cyc;
  assign dbg_w_ack      = |s_ack;
  assign dbg_w_err      = err_i;
  assign dbg_w_sel      = sel_p0;
  assign dbg_w_stb      = bus_stb;
  assign dbg_cti        = cti_p0;

endmodule

// File: tb/tb_wishbone_top.sv
// Directed testbench for wishbone_top: burst/tagged access, counter rules, errors,
// byte selects, abort and asynchronous reset.
module tb_wishbone_top;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  addr_o = '0;
  logic [31:0] data_o = '0;
  logic        we_o = 1'b0;
  logic [1:0]  stb_o = '0;
  logic        cyc_o = 1'b0;
  logic [3:0]  sel_o = '0;
  logic [2:0]  cti_input = '0;
  logic        tag_add = 1'b0;
  logic        ack_i, err_i, dbg_w_we, dbg_tag_add, dbg_w_cyc, dbg_w_ack, dbg_w_err;
  logic [31:0] data_i, dbg_w_data_m2s, dbg_w_data_s2m;
  logic [1:0]  state_out, dbg_w_stb;
  logic [3:0]  dbg_w_addr, counter, dbg_w_sel;
  logic [2:0]  dbg_cti;

  int checks = 0;
  int failures = 0;

  logic [1:0]  st_req, st_resp, st_end;
  logic        r_ack, r_err, ack_end;
  logic [31:0] r_data;
  logic [3:0]  r_ea;

  wishbone_top #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_o(addr_o), .data_o(data_o), .we_o(we_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .sel_o(sel_o), .cti_input(cti_input), .tag_add(tag_add),
    .ack_i(ack_i), .err_i(err_i), .data_i(data_i), .state_out(state_out),
    .dbg_w_addr(dbg_w_addr), .dbg_w_data_m2s(dbg_w_data_m2s), .dbg_w_data_s2m(dbg_w_data_s2m),
    .counter(counter), .dbg_w_we(dbg_w_we), .dbg_tag_add(dbg_tag_add), .dbg_w_cyc(dbg_w_cyc),
    .dbg_w_ack(dbg_w_ack), .dbg_w_err(dbg_w_err), .dbg_w_sel(dbg_w_sel), .dbg_w_stb(dbg_w_stb),
    .dbg_cti(dbg_cti)
  );

  always #5 clk_i = ~clk_i;

  // One complete request: raise, observe REQ, observe response, drop strobe, observe return.
  task automatic xfer(input logic [1:0] stb, input logic we, input logic [3:0] addr,
                      input logic [31:0] wd, input logic [3:0] sel, input logic [2:0] cti,
                      input logic tag);
    @(negedge clk_i);
    cyc_o = 1'b1; stb_o = stb; we_o = we; addr_o = addr; data_o = wd;
    sel_o = sel; cti_input = cti; tag_add = tag;
    @(posedge clk_i); #1;
    st_req = state_out; r_ea = dbg_w_addr;
    @(posedge clk_i); #1;
    st_resp = state_out; r_ack = ack_i; r_err = err_i; r_data = data_i;
    @(negedge clk_i);
    cyc_o = 1'b0; stb_o = 2'b00; cti_input = 3'b000; tag_add = 1'b0;
    @(posedge clk_i); #1;
    st_end = state_out; ack_end = ack_i | err_i;
  endtask

  task automatic test_reset();
    #20;
    checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    checks++; if (counter !== 4'd0) begin failures++; $display("FAIL reset_counter got=%0d exp=0", counter); end
    checks++; if ({ack_i, err_i} !== 2'b00) begin failures++; $display("FAIL reset_ack_err got=%b exp=00", {ack_i, err_i}); end
    checks++; if (data_i !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_i); end
    checks++; if (dbg_w_stb !== 2'b00 || dbg_w_addr !== 4'd0) begin failures++; $display("FAIL reset_dbg got=%b/%h exp=00/0", dbg_w_stb, dbg_w_addr); end
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (state_out !== 2'd0 || counter !== 4'd0 || ack_i !== 1'b0) begin failures++; $display("FAIL post_release got=%0d/%0d/%b exp=0/0/0", state_out, counter, ack_i); end
  endtask

  task automatic test_burst_write();
    logic [3:0]  ad [3] = '{4'd0, 4'd0, 4'd9};
    logic [31:0] wd [3] = '{32'h00001111, 32'h00002222, 32'h00002222};
    logic [3:0]  ea [3] = '{4'd0, 4'd1, 4'd11};
    for (int i = 0; i < 3; i++) begin
      xfer(2'b10, 1'b1, ad[i], wd[i], 4'hF, 3'b010, 1'b0);
      checks++; if (r_ea !== ea[i]) begin failures++; $display("FAIL burst_ea[%0d] got=%0d exp=%0d", i, r_ea, ea[i]); end
      checks++; if ({st_req, st_resp, st_end} !== {2'd1, 2'd2, 2'd0}) begin failures++; $display("FAIL burst_states[%0d] got=%0d,%0d,%0d exp=1,2,0", i, st_req, st_resp, st_end); end
      checks++; if ({r_ack, r_err, ack_end} !== 3'b100) begin failures++; $display("FAIL burst_ack[%0d] got=%b exp=100", i, {r_ack, r_err, ack_end}); end
    end
    checks++; if (counter !== 4'd3) begin failures++; $display("FAIL burst_counter got=%0d exp=3", counter); end
  endtask

  task automatic test_tagged_read();
    xfer(2'b10, 1'b0, 4'd0, 32'h0, 4'hF, 3'b010, 1'b1);
    checks++; if (r_data !== 32'h00001111 || !r_ack) begin failures++; $display("FAIL tread_0 got=%h ack=%b exp=00001111 ack=1", r_data, r_ack); end
    checks++; if (counter !== 4'd3) begin failures++; $display("FAIL tread_counter got=%0d exp=3", counter); end
    xfer(2'b10, 1'b0, 4'd1, 32'h0, 4'hF, 3'b010, 1'b1);
    checks++; if (r_data !== 32'h00002222) begin failures++; $display("FAIL tread_1 got=%h exp=00002222", r_data); end
    xfer(2'b10, 1'b0, 4'd11, 32'h0, 4'hF, 3'b000, 1'b1);
    checks++; if (r_data !== 32'h00002222) begin failures++; $display("FAIL tread_11 got=%h exp=00002222", r_data); end
    xfer(2'b01, 1'b0, 4'd0, 32'h0, 4'hF, 3'b000, 1'b1);
    checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL tread_s0 got=%h exp=0", r_data); end
  endtask

  task automatic test_counter_clear();
    @(negedge clk_i); cyc_o = 1'b0; cti_input = 3'b111;
    @(posedge clk_i); #1;
    checks++; if (counter !== 4'd0) begin failures++; $display("FAIL eob_clear got=%0d exp=0", counter); end
    @(negedge clk_i); cti_input = 3'b000;
    xfer(2'b01, 1'b1, 4'd0, 32'h11110000, 4'hF, 3'b010, 1'b0);
    xfer(2'b01, 1'b1, 4'd0, 32'h00001111, 4'hF, 3'b010, 1'b0);
    checks++; if (counter !== 4'd2) begin failures++; $display("FAIL s0_burst_counter got=%0d exp=2", counter); end
    xfer(2'b01, 1'b0, 4'd0, 32'h0, 4'hF, 3'b000, 1'b1);
    checks++; if (r_data !== 32'h11110000) begin failures++; $display("FAIL s0_word0 got=%h exp=11110000", r_data); end
    xfer(2'b01, 1'b0, 4'd1, 32'h0, 4'hF, 3'b000, 1'b1);
    checks++; if (r_data !== 32'h00001111) begin failures++; $display("FAIL s0_word1 got=%h exp=00001111", r_data); end
    xfer(2'b01, 1'b0, 4'd2, 32'h0, 4'hF, 3'b010, 1'b1);
    checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL s0_word2 got=%h exp=0", r_data); end
  endtask

  task automatic test_errors();
    xfer(2'b11, 1'b1, 4'd0, 32'hDEADBEEF, 4'hF, 3'b010, 1'b0);
    checks++; if ({st_resp, r_err, r_ack, st_end} !== {2'd3, 1'b1, 1'b0, 2'd0}) begin failures++; $display("FAIL err_stb got=%0d/%b/%b/%0d exp=3/1/0/0", st_resp, r_err, r_ack, st_end); end
    checks++; if (counter !== 4'd2) begin failures++; $display("FAIL err_stb_counter got=%0d exp=2", counter); end
    xfer(2'b10, 1'b1, 4'd0, 32'hFFFFFFFF, 4'h0, 3'b010, 1'b0);
    checks++; if ({st_resp, r_err, r_ack} !== {2'd3, 1'b1, 1'b0}) begin failures++; $display("FAIL err_sel got=%0d/%b/%b exp=3/1/0", st_resp, r_err, r_ack); end
    checks++; if (counter !== 4'd2) begin failures++; $display("FAIL err_sel_counter got=%0d exp=2", counter); end
    xfer(2'b01, 1'b0, 4'd0, 32'h0, 4'hF, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h11110000) begin failures++; $display("FAIL err_s0_intact got=%h exp=11110000", r_data); end
    xfer(2'b10, 1'b0, 4'd0, 32'h0, 4'hF, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h00001111) begin failures++; $display("FAIL err_s1_intact got=%h exp=00001111", r_data); end
  endtask

  task automatic test_byte_select();
    xfer(2'b01, 1'b1, 4'd0, 32'hAABBCCDD, 4'b0001, 3'b000, 1'b0);
    xfer(2'b01, 1'b0, 4'd0, 32'h0, 4'hF, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h111100DD) begin failures++; $display("FAIL bsel_write got=%h exp=111100DD", r_data); end
    xfer(2'b01, 1'b0, 4'd0, 32'h0, 4'b1100, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h11110000) begin failures++; $display("FAIL bsel_read got=%h exp=11110000", r_data); end
    xfer(2'b01, 1'b1, 4'd3, 32'h00000033, 4'hF, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h11110000 || !r_ack) begin failures++; $display("FAIL data_hold got=%h ack=%b exp=11110000 ack=1", r_data, r_ack); end
  endtask

  task automatic test_abort();
    @(negedge clk_i);
    cyc_o = 1'b1; stb_o = 2'b10; we_o = 1'b1; addr_o = 4'd5; data_o = 32'h55;
    sel_o = 4'hF; cti_input = 3'b000; tag_add = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (state_out !== 2'd1) begin failures++; $display("FAIL abort_req got=%0d exp=1", state_out); end
    @(negedge clk_i); cyc_o = 1'b0; stb_o = 2'b00;
    @(posedge clk_i); #1;
    checks++; if (state_out !== 2'd0 || ack_i !== 1'b0) begin failures++; $display("FAIL abort_idle got=%0d/%b exp=0/0", state_out, ack_i); end
    xfer(2'b10, 1'b0, 4'd5, 32'h0, 4'hF, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL abort_nowrite got=%h exp=0", r_data); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    cyc_o = 1'b1; stb_o = 2'b10; we_o = 1'b1; addr_o = 4'd0; data_o = 32'hFFFF;
    sel_o = 4'hF; cti_input = 3'b000; tag_add = 1'b0;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    checks++; if (state_out !== 2'd0 || counter !== 4'd0) begin failures++; $display("FAIL rst_mid got=%0d/%0d exp=0/0", state_out, counter); end
    cyc_o = 1'b0; stb_o = 2'b00;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    xfer(2'b10, 1'b0, 4'd1, 32'h0, 4'hF, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h0 || !r_ack) begin failures++; $display("FAIL rst_mem1 got=%h ack=%b exp=0 ack=1", r_data, r_ack); end
    xfer(2'b01, 1'b0, 4'd0, 32'h0, 4'hF, 3'b000, 1'b0);
    checks++; if (r_data !== 32'h0) begin failures++; $display("FAIL rst_mem0 got=%h exp=0", r_data); end
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_tagged_read();
    test_counter_clear();
    test_errors();
    test_byte_select();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
